// File: rtl/ram_bit_serializer.sv
// Multi-lane bit-serial readout: loads one WIDTH-bit word per lane, then emits one
// selected bit per lane per beat under a valid/ready handshake, streaming words back-to-back.
module ram_bit_serializer #(
    parameter int  WIDTH = 16,
    parameter int  LANES = 4,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_msb_first,
    input  logic [SEL_W-1:0]       in_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_bits,
    output logic [SEL_W-1:0]       out_idx,
    output logic                   out_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(WIDTH - 1);

    state_t                 state;
    logic [LANES*WIDTH-1:0] word;
    logic                   mode;
    logic [SEL_W-1:0]       len;
    logic [SEL_W-1:0]       cnt;
    logic                   take;
    logic                   load;

    assign out_valid = (state == SHIFT);
    assign out_idx   = mode ? (MAX_IDX - cnt) : cnt;
    assign out_last  = out_valid && (cnt == len);
    assign take      = out_valid && out_ready;
    // Accepting the last beat frees the word store in the same cycle, so a new word can follow with no bubble.
    assign in_ready  = (state == IDLE) || (take && out_last);
    assign load      = in_valid && in_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] lane_word;
        assign lane_word   = word[l*WIDTH +: WIDTH];
        assign out_bits[l] = lane_word[out_idx];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            // NOTE: the word store is a small register bank, reset so out_bits reads 0 straight out of reset.
            word  <= '0;
            mode  <= 1'b0;
            len   <= '0;
            cnt   <= '0;
        end else if (load) begin
            word  <= in_data;
            mode  <= in_msb_first;
            len   <= in_len;
            cnt   <= '0;
            state <= SHIFT;
        end else if (take) begin
            if (out_last) begin
                state <= IDLE;
            end else begin
                cnt <= cnt + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_bit_serializer.sv
// Directed bench for ram_bit_serializer: reset, LSB/MSB orders, partial lengths,
// back-to-back streaming, backpressure and reset mid-word.
module tb_ram_bit_serializer;

    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int SEL_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_msb_first;
    logic [SEL_W-1:0]       in_len;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0]       out_bits;
    logic [SEL_W-1:0]       out_idx;
    logic                   out_last;

    int checks   = 0;
    int failures = 0;

    localparam logic [LANES*WIDTH-1:0] D0 = 64'h0000_0000_0000_8E8E;
    localparam logic [LANES*WIDTH-1:0] DA = 64'hF00F_00FF_ABCD_1234;
    localparam logic [LANES*WIDTH-1:0] DB = 64'h5A5A_8001_7FFE_C3C3;
    localparam logic [LANES*WIDTH-1:0] D1 = 64'h0F0F_F0F0_AAAA_5555;
    localparam logic [LANES*WIDTH-1:0] D2 = 64'h1111_2222_4444_800F;

    ram_bit_serializer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_msb_first(in_msb_first),
        .in_len      (in_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .out_idx     (out_idx),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference selection: bit idx of each lane word.
    function automatic logic [LANES-1:0] model_bits(input logic [LANES*WIDTH-1:0] d, input int idx);
        logic [LANES-1:0] r;
        for (int l = 0; l < LANES; l++) r[l] = d[l*WIDTH + idx];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [LANES*WIDTH-1:0] d, input int idx,
                              input logic last, input logic rdy);
        check({tag, " out_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " out_idx"},   64'(out_idx),   64'(idx));
        check({tag, " out_bits"},  64'(out_bits),  64'(model_bits(d, idx)));
        check({tag, " out_last"},  64'(out_last),  64'(last));
        check({tag, " in_ready"},  64'(in_ready),  64'(rdy));
    endtask

    task automatic check_idle(input string tag);
        #2;
        check({tag, " idle out_valid"}, 64'(out_valid), 64'(1'b0));
        check({tag, " idle in_ready"},  64'(in_ready),  64'(1'b1));
        check({tag, " idle out_last"},  64'(out_last),  64'(1'b0));
    endtask

    task automatic load(input string tag, input logic [LANES*WIDTH-1:0] d, input logic msb, input int len);
        in_valid     = 1'b1;
        in_data      = d;
        in_msb_first = msb;
        in_len       = SEL_W'(len);
        #2;
        check({tag, " load in_ready"}, 64'(in_ready), 64'(1'b1));
        tick();
        in_valid     = 1'b0;
        in_data      = '1;
        in_msb_first = ~msb;
        in_len       = '1;
    endtask

    // Presents beats first..last of a word with out_ready held high.
    task automatic run_beats(input string tag, input logic [LANES*WIDTH-1:0] d, input logic msb,
                             input int len, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            #2;
            check_beat($sformatf("%s k%0d", tag, k), d, msb ? (WIDTH - 1 - k) : k, k == len, k == len);
            tick();
        end
    endtask

    initial begin
        logic [5:0] pat;
        int         accepted;
        int         cycles;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_msb_first = 1'b0;
        in_len       = '0;
        out_ready    = 1'b0;
        #2;
        check("rst in_ready",  64'(in_ready),  64'(1'b1));
        check("rst out_valid", 64'(out_valid), 64'(1'b0));
        check("rst out_bits",  64'(out_bits),  64'(0));
        check("rst out_idx",   64'(out_idx),   64'(0));
        check("rst out_last",  64'(out_last),  64'(1'b0));
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // LSB-first full word on lane 0
        load("lsb16", D0, 1'b0, 15);
        run_beats("lsb16", D0, 1'b0, 15, 0, 15);
        check_idle("lsb16");

        // MSB-first partial word, then a single-beat word
        load("msb4", D0, 1'b1, 3);
        run_beats("msb4", D0, 1'b1, 3, 0, 3);
        check_idle("msb4");
        load("len0", D0, 1'b1, 0);
        run_beats("len0", D0, 1'b1, 0, 0, 0);
        check_idle("len0");

        // Back-to-back: B offered during A's last beat
        load("b2b_a", DA, 1'b0, 2);
        run_beats("b2b_a", DA, 1'b0, 2, 0, 1);
        in_valid     = 1'b1;
        in_data      = DB;
        in_msb_first = 1'b1;
        in_len       = SEL_W'(1);
        #2;
        check_beat("b2b_a k2", DA, 2, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '1;
        run_beats("b2b_b", DB, 1'b1, 1, 0, 1);
        check_idle("b2b");

        // Backpressure: out_ready pattern 1,0,0,1,0,1 repeating over an 8-beat word
        pat      = 6'b101001;
        accepted = 0;
        cycles   = 0;
        load("bp", D1, 1'b0, 7);
        while (accepted < 8 && cycles < 40) begin
            out_ready = pat[cycles % 6];
            #2;
            check_beat($sformatf("bp c%0d", cycles), D1, accepted, accepted == 7,
                       (accepted == 7) && out_ready);
            if (out_ready) accepted++;
            cycles++;
            tick();
        end
        out_ready = 1'b1;
        check("bp accepted", 64'(accepted), 64'(8));
        check("bp cycles",   64'(cycles),   64'(16));
        check_idle("bp");

        // Reset mid-word after 5 accepted beats
        load("rstmid", D0, 1'b0, 15);
        run_beats("rstmid", D0, 1'b0, 15, 0, 4);
        #2;
        check_beat("rstmid k5", D0, 5, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstmid out_valid", 64'(out_valid), 64'(1'b0));
        check("rstmid in_ready",  64'(in_ready),  64'(1'b1));
        check("rstmid out_bits",  64'(out_bits),  64'(0));
        check("rstmid out_idx",   64'(out_idx),   64'(0));
        check("rstmid out_last",  64'(out_last),  64'(1'b0));
        tick();
        rst_n = 1'b1;
        check_idle("rstmid");
        load("post", D2, 1'b0, 3);
        run_beats("post", D2, 1'b0, 3, 0, 3);
        check_idle("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
